frame_pad_gen: RTL
==================

FRAME_PAD_GEN -- requirements
Module: frame_pad_gen

Interface
REQ-001 SHALL take parameter WIDTH, default 1920, active pixels per row.
REQ-002 SHALL take parameter HEIGHT, default 1080, active rows per frame.
REQ-003 SHALL take parameter KERNEL_SIZE, default 7, odd kernel size; BORDER = (KERNEL_SIZE-1)/2.
REQ-004 SHALL take parameter CHANNELS, default 3, colour channels per pixel.
REQ-005 SHALL take parameter DW, default 8, bits per channel.
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have port newFrame, input, 1, start pulse; honoured only in IDLE.
REQ-010 SHALL have port mode, input, 2, padding mode: 0 zero, 1 constant, 2 horizontal replicate, 3 reserved (treated as 0); sampled on the accepted newFrame.
REQ-011 SHALL have port padValue, input, CHANNELS*DW, constant pad pixel; sampled with mode.
REQ-012 SHALL have ports iValid, input, 1 and iData, input, CHANNELS*DW for the upstream pixel stream.
REQ-013 SHALL have port oReady, output, 1, upstream may transfer when iValid&&oReady.
REQ-014 SHALL have ports oValid, output, 1 and oData, output, CHANNELS*DW for the padded pixel stream.
REQ-015 SHALL have port iReady, input, 1, downstream ready; an output beat completes when oValid&&iReady.
REQ-016 SHALL have ports oSof, output, 1 and oEol, output, 1, flags qualifying the first beat of the frame and the last beat of each row.
REQ-017 SHALL have port oDone, output, 1, one-cycle pulse after the last frame beat completes.

Function
REQ-018 SHALL emit (WIDTH+2*BORDER)*(HEIGHT+2*BORDER) beats per frame, row-major.
REQ-019 SHALL implement states IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM, DONE.
REQ-020 SHALL move IDLE->TOP on newFrame, TOP->LEFT after BORDER full pad rows, LEFT->BODY after BORDER beats, BODY->RIGHT after WIDTH beats, RIGHT->LEFT (more rows) or RIGHT->BOTTOM (after HEIGHT rows), BOTTOM->DONE after BORDER pad rows, and DONE->IDLE after one cycle with oDone=1.
REQ-021 SHALL assert oReady only in BODY with the output register empty or being drained (iReady=1).
REQ-022 SHALL hold oValid, oData, oSof and oEol stable while oValid=1 and iReady=0.
REQ-023 SHALL register the output with one cycle of latency from an accepted input beat to oValid.
REQ-024 SHALL emit pad beats in TOP, LEFT, RIGHT and BOTTOM without consuming input.
REQ-025 SHALL set pad pixel data to 0 in mode 0 and to padValue in mode 1.
REQ-026 SHALL, in mode 2, send the row's first active pixel for LEFT pads and its last active pixel for RIGHT pads, and send zero for TOP/BOTTOM rows.
REQ-027 SHALL, in mode 2, stall LEFT with oValid=0 until the row's first input beat arrives, then emit the LEFT pads followed by that pixel.
REQ-028 SHALL ignore newFrame outside IDLE and SHALL give no extra beat when newFrame coincides with DONE.
REQ-029 SHALL size its x/y counters as $clog2 of the padded width and height and wrap them to 0 at row and frame end.

Reset
REQ-030 SHALL, on reset=0 at a clock edge including mid-frame, enter IDLE, clear the counters, and drive oValid, oReady, oSof, oEol and oDone to 0 and oData to 0.
REQ-031 SHALL NOT emit a partial-frame remainder after reset is released.

Configuration
REQ-032 SHALL implement mode 2 and its pixel-hold registers only when PAD_REPLICATE_EN is defined.
REQ-033 SHALL, without PAD_REPLICATE_EN, treat mode 2 as mode 0 and never stall LEFT.

Structure
REQ-034 SHALL take the state enum, mode encodings and BORDER derivation from the shared package isp_pkg.
REQ-035 SHALL contain one sub-module, pad_counter, a parametrised x/y position counter with wrap flags.

Verification
Scenarios use WIDTH=4, HEIGHT=3, KERNEL_SIZE=3, CHANNELS=3, DW=8, with iReady=1 unless stated.
REQ-036 SHALL cover mode 0 with 12 input pixels 1..12: 30 beats; rows 0 and 4 all zero; row 1 = 0,1,2,3,4,0; oSof on beat 0; oEol every 6th beat; oDone once.
REQ-037 SHALL cover mode 1 with padValue=0x102030: every pad beat = 0x102030 and active pixels pass through unchanged.
REQ-038 SHALL cover mode 2 with PAD_REPLICATE_EN and row 1 input 5,6,7,8: output 5,5,6,7,8,8.
REQ-039 SHALL cover iReady toggling 1,0 every cycle: the output sequence matches the mode 0 scenario and data is held during stalls.
REQ-040 SHALL cover reset=0 at beat 14: all outputs 0 next cycle; a subsequent newFrame yields a clean 30-beat frame.
REQ-041 SHALL cover newFrame pulsed during BODY: ignored, beat count stays 30.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared ISP definitions: padding FSM states, pad mode encodings and kernel border helper.
package isp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOP,
        ST_LEFT,
        ST_BODY,
        ST_RIGHT,
        ST_BOTTOM,
        ST_DONE
    } pad_state_t;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_REPL  = 2'd2,
        MODE_RSVD  = 2'd3
    } pad_mode_t;

    function automatic int border_of(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/pad_counter.sv
// x/y raster position counter over the padded frame; wraps both axes to 0 at frame end.
module pad_counter #(
    parameter int PW = 6,
    parameter int PH = 5,
    parameter int XW = $clog2(PW),
    parameter int YW = $clog2(PH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_last,
    output logic          y_last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x      = x_q;
    assign y      = y_q;
    assign x_last = (x_q == XW'(PW - 1));
    assign y_last = (y_q == YW'(PH - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (inc) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_pad_gen.sv
// Border padding generator: wraps a WIDTH x HEIGHT pixel stream with BORDER pad pixels on every side.
// Horizontal replicate padding (mode 2) is built only when PAD_REPLICATE_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for newFrame
//   TOP    | BORDER full rows of pad beats
//   LEFT   | BORDER pad beats at row start
//   BODY   | WIDTH active pixels passed through
//   RIGHT  | BORDER pad beats at row end
//   BOTTOM | BORDER full rows of pad beats
//   DONE   | wait for last beat to drain, pulse oDone
module frame_pad_gen
    import isp_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int KERNEL_SIZE = 7,
    parameter int CHANNELS    = 3,
    parameter int DW          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   newFrame,
    input  logic [1:0]             mode,
    input  logic [CHANNELS*DW-1:0] padValue,
    input  logic                   iValid,
    input  logic [CHANNELS*DW-1:0] iData,
    output logic                   oReady,
    output logic                   oValid,
    output logic [CHANNELS*DW-1:0] oData,
    input  logic                   iReady,
    output logic                   oSof,
    output logic                   oEol,
    output logic                   oDone
);

    localparam int BORDER = border_of(KERNEL_SIZE);
    localparam int PW     = WIDTH + 2 * BORDER;
    localparam int PH     = HEIGHT + 2 * BORDER;
    localparam int XW     = $clog2(PW);
    localparam int YW     = $clog2(PH);
    localparam int PXW    = CHANNELS * DW;

    pad_state_t     state_q, state_d;
    pad_mode_t      mode_q, mode_d;
    logic [PXW-1:0] pad_val_q, pad_val_d;
    logic           out_valid_q, out_valid_d;
    logic [PXW-1:0] out_data_q, out_data_d;
    logic           out_sof_q, out_sof_d;
    logic           out_eol_q, out_eol_d;

`ifdef PAD_REPLICATE_EN
    logic [PXW-1:0] left_pix_q, left_pix_d;
    logic           left_have_q, left_have_d;
    logic [PXW-1:0] right_pix_q, right_pix_d;
    logic           repl;
`endif

    logic           cnt_clr, cnt_inc;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           x_last, y_last;
    logic           load, emit, in_ready, done;
    logic [PXW-1:0] emit_val, pad_fill;

    pad_counter #(
        .PW(PW),
        .PH(PH),
        .XW(XW),
        .YW(YW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .x     (x),
        .y     (y),
        .x_last(x_last),
        .y_last(y_last)
    );

    assign oReady = in_ready;
    assign oValid = out_valid_q;
    assign oData  = out_data_q;
    assign oSof   = out_sof_q;
    assign oEol   = out_eol_q;
    assign oDone  = done;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pad_val_d   = pad_val_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        in_ready    = 1'b0;
        done        = 1'b0;
        emit        = 1'b0;
        emit_val    = '0;
`ifdef PAD_REPLICATE_EN
        left_pix_d  = left_pix_q;
        left_have_d = left_have_q;
        right_pix_d = right_pix_q;
        repl        = (mode_q == MODE_REPL);
`endif

        // The output register accepts a new beat when empty or when its beat leaves this cycle.
        load     = !out_valid_q || iReady;
        pad_fill = (mode_q == MODE_CONST) ? pad_val_q : '0;
        if (out_valid_q && iReady) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (newFrame) begin
                    state_d   = ST_TOP;
                    pad_val_d = padValue;
                    cnt_clr   = 1'b1;
                    case (mode)
                        2'd1:    mode_d = MODE_CONST;
`ifdef PAD_REPLICATE_EN
                        2'd2:    mode_d = MODE_REPL;
`endif
                        default: mode_d = MODE_ZERO;
                    endcase
                end
            end
            ST_TOP: begin
                if (load) begin
                    emit     = 1'b1;
                    emit_val = pad_fill;
                    if (x_last && y == YW'(BORDER - 1)) begin
                        state_d = ST_LEFT;
                    end
                end
            end
            ST_LEFT: begin
`ifdef PAD_REPLICATE_EN
                // Replicate peeks the pending first pixel; it is consumed later in BODY.
                if (repl && !left_have_q && iValid) begin
                    left_pix_d  = iData;
                    left_have_d = 1'b1;
                end
                if (load && (!repl || left_have_q || iValid)) begin
                    emit     = 1'b1;
                    emit_val = !repl ? pad_fill : (left_have_q ? left_pix_q : iData);
                    if (x == XW'(BORDER - 1)) begin
                        state_d = ST_BODY;
                    end
                end
`else
                if (load) begin
                    emit     = 1'b1;
                    emit_val = pad_fill;
                    if (x == XW'(BORDER - 1)) begin
                        state_d = ST_BODY;
                    end
                end
`endif
            end
            ST_BODY: begin
                in_ready = load;
                if (iValid && load) begin
                    emit     = 1'b1;
                    emit_val = iData;
`ifdef PAD_REPLICATE_EN
                    right_pix_d = iData;
`endif
                    if (x == XW'(BORDER + WIDTH - 1)) begin
                        state_d = ST_RIGHT;
                    end
                end
            end
            ST_RIGHT: begin
                if (load) begin
                    emit     = 1'b1;
`ifdef PAD_REPLICATE_EN
                    emit_val = repl ? right_pix_q : pad_fill;
`else
                    emit_val = pad_fill;
`endif
                    if (x_last) begin
`ifdef PAD_REPLICATE_EN
                        left_have_d = 1'b0;
`endif
                        state_d = (y == YW'(BORDER + HEIGHT - 1)) ? ST_BOTTOM : ST_LEFT;
                    end
                end
            end
            ST_BOTTOM: begin
                if (load) begin
                    emit     = 1'b1;
                    emit_val = pad_fill;
                    if (x_last && y_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_val;
            out_sof_d   = (x == '0) && (y == '0);
            out_eol_d   = x_last;
            cnt_inc     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ZERO;
            pad_val_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
`ifdef PAD_REPLICATE_EN
            left_pix_q  <= '0;
            left_have_q <= 1'b0;
            right_pix_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pad_val_q   <= pad_val_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
`ifdef PAD_REPLICATE_EN
            left_pix_q  <= left_pix_d;
            left_have_q <= left_have_d;
            right_pix_q <= right_pix_d;
`endif
        end
    end

endmodule
